// File: rtl/instr_prefetch_buffer.sv
// Instruction prefetch buffer: fetches sequential words into a DEPTH-entry FIFO feeding IF/ID.
// Optional discarded-fetch statistics are built when PREFETCH_STATS_EN is defined.
module instr_prefetch_buffer #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        Redirect,
    input  logic [31:0] RedirectAddr,
    input  logic        Stall,
    output logic        out_valid,
    output logic [31:0] out_Instruction,
    output logic [31:0] out_PCAddResult,
    output logic [31:0] fetch_pc,
    output logic [15:0] discard_count
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned DW = CW + 1;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_add;
    } entry_t;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t         r_state;
    logic [31:0]    r_fetch_pc;
    logic           r_req;
    logic [31:0]    r_addr;
    logic [CW-1:0]  r_count;
    logic [AW-1:0]  r_rd_ptr;
    logic [AW-1:0]  r_wr_ptr;
    entry_t         r_mem [DEPTH];

    state_t         w_state_nxt;
    logic [31:0]    w_pc_nxt;
    logic [31:0]    w_addr_nxt;
    logic           w_xfer;
    logic           w_enq;
    logic           w_deq;
    logic [31:0]    w_pc_plus4;
    logic [CW-1:0]  w_count_upd;
    entry_t         w_head;

    assign w_xfer      = r_req & imem_ack;
    assign w_enq       = (r_state == S_REQ) & w_xfer & ~Redirect;
    assign w_deq       = out_valid & ~Stall & ~Redirect;
    assign w_pc_plus4  = r_fetch_pc + 32'd4;
    assign w_count_upd = r_count + CW'(w_enq) - CW'(w_deq);

    // Next-state, next fetch address and the held request address.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_fetch_pc;
        w_addr_nxt  = r_addr;
        case (r_state)
            S_IDLE: begin
                if (Redirect) begin
                    w_pc_nxt    = RedirectAddr;
                    w_state_nxt = S_REQ;
                end else if (r_count < CW'(DEPTH)) begin
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (Redirect) begin
                    w_pc_nxt    = RedirectAddr;
                    w_state_nxt = w_xfer ? S_REQ : S_DISCARD;
                end else if (w_xfer) begin
                    w_pc_nxt    = w_pc_plus4;
                    w_state_nxt = (w_count_upd < CW'(DEPTH)) ? S_REQ : S_IDLE;
                end
            end
            S_DISCARD: begin
                if (Redirect) begin
                    w_pc_nxt = RedirectAddr;
                end
                if (w_xfer) begin
                    w_state_nxt = S_REQ;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // An abandoned request keeps presenting its original address until acked.
        if (w_state_nxt == S_DISCARD) begin
            w_addr_nxt = (r_state == S_DISCARD) ? r_addr : r_fetch_pc;
        end else begin
            w_addr_nxt = w_pc_nxt;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state    <= S_IDLE;
            r_fetch_pc <= RESET_PC;
            r_req      <= 1'b0;
            r_addr     <= RESET_PC;
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_pc <= w_pc_nxt;
            r_req      <= (w_state_nxt != S_IDLE);
            r_addr     <= w_addr_nxt;
            if (Redirect) begin
                r_count  <= '0;
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
            end else begin
                r_count <= w_count_upd;
                if (w_enq) begin
                    r_wr_ptr <= r_wr_ptr + AW'(1);
                end
                if (w_deq) begin
                    r_rd_ptr <= r_rd_ptr + AW'(1);
                end
            end
        end
    end

    // Payload storage needs no reset; the head is masked while empty.
    always_ff @(posedge Clk) begin
        if (w_enq) begin
            r_mem[r_wr_ptr] <= '{instr: imem_rdata, pc_add: w_pc_plus4};
        end
    end

    assign w_head          = r_mem[r_rd_ptr];
    assign out_valid       = (r_count != '0);
    assign out_Instruction = out_valid ? w_head.instr  : 32'h0;
    assign out_PCAddResult = out_valid ? w_head.pc_add : 32'h0;
    assign imem_req        = r_req;
    assign imem_addr       = r_addr;
    assign fetch_pc        = r_fetch_pc;

`ifdef PREFETCH_STATS_EN
    logic [15:0]   r_discard_count;
    logic [DW-1:0] w_drop;
    logic [16:0]   w_disc_sum;

    // Dropped fetches: flushed entries plus any response that arrives for an abandoned request.
    assign w_drop     = (Redirect ? DW'(r_count) : DW'(0))
                      + DW'(w_xfer & ((r_state == S_DISCARD) | Redirect));
    assign w_disc_sum = {1'b0, r_discard_count} + 17'(w_drop);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_discard_count <= 16'h0;
        end else begin
            r_discard_count <= w_disc_sum[16] ? 16'hFFFF : w_disc_sum[15:0];
        end
    end

    assign discard_count = r_discard_count;
`else
    assign discard_count = 16'h0;
`endif

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Directed self-checking bench for instr_prefetch_buffer with a variable-latency memory model.
module tb_instr_prefetch_buffer;

    logic        Clk;
    logic        Reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        Redirect;
    logic [31:0] RedirectAddr;
    logic        Stall;
    logic        out_valid;
    logic [31:0] out_Instruction;
    logic [31:0] out_PCAddResult;
    logic [31:0] fetch_pc;
    logic [15:0] discard_count;

    int n_checks = 0;
    int n_errors = 0;

`ifdef PREFETCH_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    instr_prefetch_buffer #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .Clk             (Clk),
        .Reset           (Reset),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .Redirect        (Redirect),
        .RedirectAddr    (RedirectAddr),
        .Stall           (Stall),
        .out_valid       (out_valid),
        .out_Instruction (out_Instruction),
        .out_PCAddResult (out_PCAddResult),
        .fetch_pc        (fetch_pc),
        .discard_count   (discard_count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Memory model: word at address a is a ^ 32'hDEAD0000, acked after ack_delay wait cycles.
    logic [31:0] ack_delay = 32'd0;
    logic [31:0] r_wait    = 32'd0;
    int          ack_cnt   = 0;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'hDEAD0000;
    endfunction

    function automatic logic [31:0] exp_disc(input logic [31:0] n);
        return STATS ? n : 32'd0;
    endfunction

    assign imem_ack   = imem_req && (r_wait >= ack_delay);
    assign imem_rdata = instr_of(imem_addr);

    always @(posedge Clk) begin
        if (imem_req && imem_ack) begin
            r_wait  <= 32'd0;
            ack_cnt <= ack_cnt + 1;
        end else if (imem_req) begin
            r_wait <= r_wait + 32'd1;
        end else begin
            r_wait <= 32'd0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_head(input string tag, input logic [31:0] a);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_instr"}, out_Instruction, instr_of(a));
        check({tag, "_pc4"},   out_PCAddResult, a + 32'd4);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acks_before;
        Reset        = 1'b0;
        Redirect     = 1'b0;
        RedirectAddr = 32'h0;
        Stall        = 1'b0;

        // Reset state and first-fetch latency with a same-cycle-ack memory.
        @(negedge Clk);
        check("rst_valid",   32'(out_valid), 32'd0);
        check("rst_req",     32'(imem_req),  32'd0);
        check("rst_pc",      fetch_pc,       32'h0);
        check("rst_disc",    32'(discard_count), 32'd0);
        check("rst_instr",   out_Instruction, 32'h0);
        check("rst_pc4",     out_PCAddResult, 32'h0);
        Reset = 1'b1;
        @(negedge Clk);
        check("c1_req",   32'(imem_req),  32'd1);
        check("c1_addr",  imem_addr,      32'h0);
        check("c1_valid", 32'(out_valid), 32'd0);
        @(negedge Clk);
        check_head("c2", 32'h0);
        @(negedge Clk);
        check_head("c3", 32'h4);
        @(negedge Clk);
        check_head("c4", 32'h8);

        // Stall fills the FIFO, fetch idles at 16, then drains in order.
        Reset = 1'b0;
        Stall = 1'b1;
        @(negedge Clk);
        Reset = 1'b1;
        repeat (10) @(negedge Clk);
        check("full_req", 32'(imem_req), 32'd0);
        check("full_pc",  fetch_pc,      32'd16);
        check_head("full_head", 32'h0);
        Stall = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge Clk);
            check_head("drain", 32'(4 * k));
            if (k == 2) begin
                check("resume_req",  32'(imem_req), 32'd1);
                check("resume_addr", imem_addr,     32'd16);
            end
        end

        // Redirect while a slow request is outstanding: address held, data dropped.
        Reset     = 1'b0;
        ack_delay = 32'd3;
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        check("slow_addr0", imem_addr, 32'h0);
        Redirect     = 1'b1;
        RedirectAddr = 32'h100;
        @(negedge Clk);
        Redirect = 1'b0;
        check("disc_req",   32'(imem_req),  32'd1);
        check("disc_addr",  imem_addr,      32'h0);
        check("disc_pc",    fetch_pc,       32'h100);
        check("disc_valid", 32'(out_valid), 32'd0);
        @(negedge Clk);
        check("disc_addr2", imem_addr, 32'h0);
        @(negedge Clk);
        @(negedge Clk);
        check("re_req",   32'(imem_req),  32'd1);
        check("re_addr",  imem_addr,      32'h100);
        check("re_valid", 32'(out_valid), 32'd0);
        ack_delay = 32'd0;
        @(negedge Clk);
        check_head("re_head", 32'h100);
        check("re_disc", 32'(discard_count), exp_disc(32'd1));

        // Redirect coinciding with an ack and a valid, unstalled head.
        @(negedge Clk);
        Redirect     = 1'b1;
        RedirectAddr = 32'h200;
        @(negedge Clk);
        Redirect = 1'b0;
        check("rack_valid", 32'(out_valid), 32'd0);
        check("rack_instr", out_Instruction, 32'h0);
        check("rack_pc4",   out_PCAddResult, 32'h0);
        check("rack_pc",    fetch_pc,        32'h200);
        check("rack_addr",  imem_addr,       32'h200);
        check("rack_disc",  32'(discard_count), exp_disc(32'd3));
        @(negedge Clk);
        check_head("rack_head", 32'h200);

        // Flush of three entries, then a second redirect while discarding.
        Reset     = 1'b0;
        Stall     = 1'b1;
        ack_delay = 32'd0;
        @(negedge Clk);
        Reset = 1'b1;
        repeat (4) @(negedge Clk);
        check("f3_pc",    fetch_pc, 32'd12);
        check_head("f3_head", 32'h0);
        ack_delay    = 32'd5;
        Redirect     = 1'b1;
        RedirectAddr = 32'h300;
        acks_before  = ack_cnt;
        @(negedge Clk);
        check("f3_disc",  32'(discard_count), exp_disc(32'd3));
        check("f3_valid", 32'(out_valid), 32'd0);
        check("f3_req",   32'(imem_req),  32'd1);
        check("f3_addr",  imem_addr,      32'd12);
        check("f3_npc",   fetch_pc,       32'h300);
        RedirectAddr = 32'h400;
        @(negedge Clk);
        Redirect = 1'b0;
        check("dd_pc",   fetch_pc,  32'h400);
        check("dd_addr", imem_addr, 32'd12);
        for (int i = 0; i < 20; i++) begin
            if (imem_req && imem_addr == 32'h400) break;
            @(negedge Clk);
        end
        check("dd_newaddr", imem_addr, 32'h400);
        check("dd_acks",    32'(ack_cnt - acks_before), 32'd1);
        check("dd_disc",    32'(discard_count), exp_disc(32'd4));
        Stall     = 1'b0;
        ack_delay = 32'd0;
        @(negedge Clk);
        check_head("dd_head", 32'h400);

        // Asynchronous reset in the middle of an outstanding request.
        ack_delay = 32'd5;
        @(negedge Clk);
        check("mid_req", 32'(imem_req), 32'd1);
        #2 Reset = 1'b0;
        #1;
        check("ar_req",   32'(imem_req),       32'd0);
        check("ar_valid", 32'(out_valid),      32'd0);
        check("ar_pc",    fetch_pc,            32'h0);
        check("ar_disc",  32'(discard_count),  32'd0);
        check("ar_instr", out_Instruction,     32'h0);
        @(negedge Clk);
        Reset     = 1'b1;
        ack_delay = 32'd0;
        @(negedge Clk);
        check("ar_addr", imem_addr, 32'h0);
        @(negedge Clk);
        check_head("ar_head", 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/instr_prefetch_buffer.md
Name: instr_prefetch_buffer

Overview:
- Fetch-side block that sits directly upstream of the IF/ID pipeline register.
- Decouples instruction memory latency from the decode stage by fetching sequential instructions into a small FIFO.
- Each entry holds {Instruction, PCAddResult}. The FIFO head feeds IF/ID.
- A branch/jump/jr redirect from EX flushes the buffer and restarts fetch at the target.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2.
- RESET_PC, 32'h00000000, fetch address after reset.

Ports:
- Clk  input  1  clock, rising edge.
- Reset  input  1  asynchronous, active-low reset.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  32  word-aligned fetch address.
- imem_ack  input  1  memory response valid; transfer occurs on a cycle with imem_req & imem_ack.
- imem_rdata  input  32  instruction returned with imem_ack.
- Redirect  input  1  flush and restart (PCSrc / jump taken).
- RedirectAddr  input  32  new fetch address.
- Stall  input  1  hazard unit holding IF/ID; head is not consumed.
- out_valid  output  1  FIFO head valid.
- out_Instruction  output  32  head instruction; 32'h0 (NOP) when empty.
- out_PCAddResult  output  32  head fetch address + 4; 0 when empty.
- fetch_pc  output  32  next address to be fetched.
- discard_count  output  16  discarded-fetch counter (see Optional Feature).

Behaviour:
- Reset (async, Reset=0): state=IDLE, count=0, read/write pointers=0, fetch_pc=RESET_PC, imem_req=0, out_valid=0, discard_count=0.
- States: IDLE, REQ, DISCARD. imem_req = (state==REQ || state==DISCARD).
- imem_addr = fetch_pc in REQ. In DISCARD it holds the address of the abandoned request.
- Request rule: once imem_req rises, imem_req and imem_addr stay stable until ack. Requests are never aborted.
- IDLE:
  - if Redirect: load fetch_pc=RedirectAddr, flush; go to REQ.
  - else if count<DEPTH: go to REQ.
- REQ with ack and no Redirect:
  - write {imem_rdata, fetch_pc+4} at the write pointer; fetch_pc += 4.
  - next state is REQ if the post-update count < DEPTH, else IDLE.
- REQ with ack and Redirect:
  - drop the returned data; flush; fetch_pc=RedirectAddr; next state REQ.
- REQ without ack and with Redirect:
  - latch the old address as the discard address; fetch_pc=RedirectAddr; flush; go to DISCARD.
- DISCARD:
  - wait for ack and drop its data; then go to REQ at fetch_pc.
  - a Redirect in DISCARD only updates fetch_pc; the state stays DISCARD.
- Dequeue = out_valid & ~Stall & ~Redirect. It advances the read pointer; the next head is visible the following cycle.
- Simultaneous enqueue and dequeue: count is unchanged. Legal at any count including DEPTH-1.
- Flush: count=0 and pointers=0 in the same edge. Redirect has priority over both enqueue and dequeue.
- Pointer and fetch_pc arithmetic wrap modulo 2^width. A fetch_pc wrap from 32'hFFFFFFFC to 0 is not flagged.
- The FIFO never overflows because requests only issue when count<DEPTH. Reading when empty has no effect.
- Latency:
  - memory with same-cycle ack: the first instruction reaches out_valid 2 cycles after reset release or redirect (IDLE→REQ→write).
  - sustained throughput is 1 instruction/cycle while not full.

Optional Feature:
- Macro PREFETCH_STATS_EN.
- Defined: discard_count increments by 1 for each fetch dropped, whether by ack in DISCARD, ack coinciding with Redirect, or each valid entry removed by a flush. It saturates at 16'hFFFF.
- Not defined: discard_count is tied to 16'h0 and no counter logic is built.

Test Plan:
- Reset release, memory acks same cycle, Stall=0 → out_valid at cycle 2; out_Instruction sequence matches imem words at 0,4,8; out_PCAddResult = 4,8,12.
- Stall=1 held for 10 cycles, DEPTH=4 → count stops at 4, imem_req=0 in IDLE, fetch_pc=16. Release Stall → entries drain in order and fetching resumes at 16.
- Memory ack delayed 3 cycles; Redirect to 32'h00000100 in the 1st wait cycle → imem_addr held at the old address until ack; that data is not enqueued; next request at 0x100; first out_PCAddResult=0x104.
- Redirect coinciding with ack and with a non-stalled valid head → FIFO empty next cycle, out_valid=0, out_Instruction=0, no dequeue counted.
- With PREFETCH_STATS_EN, FIFO holding 3 entries then Redirect → discard_count=3. Then a redirect during DISCARD → single request at the latest RedirectAddr only.
- Reset asserted mid-REQ → all outputs return to reset values immediately (async); after release, fetch restarts at RESET_PC.
